// File: rtl/test_monitor_pkg.sv
// Shared definitions for the test monitor: state encoding and hang constants.
// Hang detection is built only when TEST_MONITOR_HANG_DETECT_EN is defined.
package test_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } mon_state_e;

    localparam int HANG_BEATS = 16;
    localparam int HANG_W     = $clog2(HANG_BEATS + 1);

endpackage

// File: rtl/watch_table.sv
// Table of NUM_CH valid+address watch entries with a combinational
// lowest-index match against the incoming pc.
module watch_table #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic                      clear,
    input  logic [$clog2(NUM_CH)-1:0] idx,
    input  logic [XLEN-1:0]           addr,
    input  logic [XLEN-1:0]           pc,
    output logic                      match,
    output logic [$clog2(NUM_CH)-1:0] match_idx
);

    localparam int IW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] valid;
    logic [XLEN-1:0]   addr_q [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
            end
        end else if (clear) begin
            valid <= '0;
        end else if (we) begin
            valid[idx]  <= 1'b1;
            addr_q[idx] <= addr;
        end
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid[i] && addr_q[i] == pc) begin
                match     = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/test_monitor.sv
// Watches the pc stream for pass/fail addresses, timeout and (optionally,
// TEST_MONITOR_HANG_DETECT_EN) a pc stuck for HANG_BEATS beats.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [XLEN-1:0]           pc,
    input  logic                      pc_valid,
    input  logic                      start,
    input  logic                      cfg_we,
    input  logic                      cfg_kind,
    input  logic [$clog2(NUM_CH)-1:0] cfg_idx,
    input  logic [XLEN-1:0]           cfg_addr,
    input  logic                      cfg_clear,
    input  logic [CNT_W-1:0]          timeout_limit,
    output logic [2:0]                state,
    output logic                      done,
    output logic [$clog2(NUM_CH)-1:0] hit_idx,
    output logic [CNT_W-1:0]          cycles,
    output logic [CNT_W-1:0]          retired
);

    localparam int IW = $clog2(NUM_CH);

    mon_state_e st, st_nx;

    logic          cfg_ok;
    logic          pass_m, fail_m;
    logic [IW-1:0] pass_i, fail_i;
    logic          pass_hit, fail_hit;
    logic          tmo_hit, hang_hit;
    logic          launch;

    assign cfg_ok = (st != ST_RUN);
    assign launch = start && (st != ST_RUN);

    watch_table #(.XLEN(XLEN), .NUM_CH(NUM_CH)) u_pass (
        .clk       (clk),
        .rst       (rst),
        .we        (cfg_ok && cfg_we && !cfg_kind),
        .clear     (cfg_ok && cfg_clear),
        .idx       (cfg_idx),
        .addr      (cfg_addr),
        .pc        (pc),
        .match     (pass_m),
        .match_idx (pass_i)
    );

    watch_table #(.XLEN(XLEN), .NUM_CH(NUM_CH)) u_fail (
        .clk       (clk),
        .rst       (rst),
        .we        (cfg_ok && cfg_we && cfg_kind),
        .clear     (cfg_ok && cfg_clear),
        .idx       (cfg_idx),
        .addr      (cfg_addr),
        .pc        (pc),
        .match     (fail_m),
        .match_idx (fail_i)
    );

    assign pass_hit = pc_valid && pass_m;
    assign fail_hit = pc_valid && fail_m;
    assign tmo_hit  = (timeout_limit != '0) &&
                      (cycles == timeout_limit - CNT_W'(1));

`ifdef TEST_MONITOR_HANG_DETECT_EN
    logic [XLEN-1:0]   last_pc;
    logic [HANG_W-1:0] same_cnt;
    logic              same;

    // A zero count means no beat seen yet this run, so last_pc is stale.
    assign same     = pc_valid && (same_cnt != '0) && (pc == last_pc);
    assign hang_hit = same && (same_cnt == HANG_W'(HANG_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc  <= '0;
            same_cnt <= '0;
        end else if (launch) begin
            same_cnt <= '0;
        end else if (st == ST_RUN && pc_valid) begin
            last_pc  <= pc;
            same_cnt <= same ? same_cnt + HANG_W'(1) : HANG_W'(1);
        end
    end
`else
    assign hang_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            ST_RUN: begin
                if (fail_hit)      st_nx = ST_FAIL;
                else if (pass_hit) st_nx = ST_PASS;
                else if (hang_hit) st_nx = ST_HANG;
                else if (tmo_hit)  st_nx = ST_TIMEOUT;
            end
            default: begin
                if (start) st_nx = ST_RUN;
            end
        endcase
    end

    always_comb begin
        state = st;
        done  = (st == ST_PASS) || (st == ST_FAIL) ||
                (st == ST_TIMEOUT) || (st == ST_HANG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles  <= '0;
            retired <= '0;
            hit_idx <= '0;
        end else if (launch) begin
            cycles  <= '0;
            retired <= '0;
            hit_idx <= '0;
        end else if (st == ST_RUN) begin
            if (!(&cycles))
                cycles <= cycles + CNT_W'(1);
            if (pc_valid && !(&retired))
                retired <= retired + CNT_W'(1);
            if (fail_hit)      hit_idx <= fail_i;
            else if (pass_hit) hit_idx <= pass_i;
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// Directed self-checking bench for test_monitor.
// Hang scenarios follow TEST_MONITOR_HANG_DETECT_EN as built.
module tb_test_monitor;

    localparam int XLEN   = 32;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_FAIL = 3'd3;
    localparam logic [2:0] S_TMO  = 3'd4;
    localparam logic [2:0] S_HANG = 3'd5;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  pc;
    logic             pc_valid;
    logic             start;
    logic             cfg_we;
    logic             cfg_kind;
    logic [1:0]       cfg_idx;
    logic [XLEN-1:0]  cfg_addr;
    logic             cfg_clear;
    logic [CNT_W-1:0] timeout_limit;
    logic [2:0]       state;
    logic             done;
    logic [1:0]       hit_idx;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] retired;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    test_monitor #(
        .XLEN   (XLEN),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .start         (start),
        .cfg_we        (cfg_we),
        .cfg_kind      (cfg_kind),
        .cfg_idx       (cfg_idx),
        .cfg_addr      (cfg_addr),
        .cfg_clear     (cfg_clear),
        .timeout_limit (timeout_limit),
        .state         (state),
        .done          (done),
        .hit_idx       (hit_idx),
        .cycles        (cycles),
        .retired       (retired)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic kind,
                      input logic [1:0] idx,
                      input logic [XLEN-1:0] a);
        cfg_we   = 1'b1;
        cfg_kind = kind;
        cfg_idx  = idx;
        cfg_addr = a;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [XLEN-1:0] p);
        pc       = p;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        pc            = '0;
        pc_valid      = 1'b0;
        start         = 1'b0;
        cfg_we        = 1'b0;
        cfg_kind      = 1'b0;
        cfg_idx       = '0;
        cfg_addr      = '0;
        cfg_clear     = 1'b0;
        timeout_limit = '0;
        tick();
        tick();
        chk("rst_state", 64'(state), 64'(S_IDLE));
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hit", 64'(hit_idx), 64'd0);
        chk("rst_cyc", 64'(cycles), 64'd0);
        chk("rst_ret", 64'(retired), 64'd0);
        rst = 1'b0;
        tick();

        // pass[0]=0x100, stream 0x0..0x100
        wr(1'b0, 2'd0, 32'h100);
        go();
        chk("p_run", 64'(state), 64'(S_RUN));
        chk("p_cyc0", 64'(cycles), 64'd0);
        for (int i = 0; i < 64; i++) beat(32'(i * 4));
        chk("p_pre", 64'(state), 64'(S_RUN));
        beat(32'h100);
        chk("p_state", 64'(state), 64'(S_PASS));
        chk("p_done", 64'(done), 64'd1);
        chk("p_hit", 64'(hit_idx), 64'd0);
        chk("p_ret", 64'(retired), 64'd65);
        chk("p_cyc", 64'(cycles), 64'd65);
        tick();
        tick();
        chk("p_hold", 64'(state), 64'(S_PASS));
        chk("p_hold_cyc", 64'(cycles), 64'd65);

        // fail wins over pass, lowest fail index
        wr(1'b0, 2'd1, 32'h200);
        wr(1'b1, 2'd2, 32'h200);
        wr(1'b1, 2'd3, 32'h200);
        go();
        chk("f_hit0", 64'(hit_idx), 64'd0);
        beat(32'h200);
        chk("f_state", 64'(state), 64'(S_FAIL));
        chk("f_hit", 64'(hit_idx), 64'd2);
        chk("f_ret", 64'(retired), 64'd1);

        // clear beats write; timeout at limit 10
        cfg_clear = 1'b1;
        wr(1'b1, 2'd0, 32'h300);
        cfg_clear = 1'b0;
        timeout_limit = 32'd10;
        go();
        chk("t_hitclr", 64'(hit_idx), 64'd0);
        chk("t_ret0", 64'(retired), 64'd0);
        for (int i = 0; i < 9; i++) beat(32'h300);
        chk("t_pre", 64'(state), 64'(S_RUN));
        beat(32'h300);
        chk("t_state", 64'(state), 64'(S_TMO));
        chk("t_cyc", 64'(cycles), 64'd10);
        chk("t_ret", 64'(retired), 64'd10);

        // match on the timeout cycle wins
        wr(1'b0, 2'd0, 32'h400);
        timeout_limit = 32'd5;
        go();
        for (int i = 0; i < 4; i++) tick();
        beat(32'h400);
        chk("tm_state", 64'(state), 64'(S_PASS));
        chk("tm_cyc", 64'(cycles), 64'd5);

        // limit 0 never times out
        timeout_limit = '0;
        go();
        for (int i = 0; i < 1000; i++) tick();
        chk("t0_state", 64'(state), 64'(S_RUN));
        chk("t0_cyc", 64'(cycles), 64'd1000);

        // cfg ignored in RUN
        wr(1'b1, 2'd0, 32'h80);
        beat(32'h80);
        chk("cr_state", 64'(state), 64'(S_RUN));

        // reset mid-run
        rst = 1'b1;
        #1;
        chk("mr_state", 64'(state), 64'(S_IDLE));
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_cyc", 64'(cycles), 64'd0);
        chk("mr_ret", 64'(retired), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        go();
        beat(32'h400);
        chk("mr_nopass", 64'(state), 64'(S_RUN));
        beat(32'h200);
        chk("mr_nofail", 64'(state), 64'(S_RUN));

        // hang detection
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        go();
        for (int i = 0; i < 15; i++) beat(32'h44);
        chk("h15", 64'(state), 64'(S_RUN));
        beat(32'h48);
        chk("h15_48", 64'(state), 64'(S_RUN));
        go();
        for (int i = 0; i < 16; i++) beat(32'h44);
`ifdef TEST_MONITOR_HANG_DETECT_EN
        chk("h16", 64'(state), 64'(S_HANG));
        chk("h16_done", 64'(done), 64'd1);
`else
        for (int i = 0; i < 8; i++) beat(32'h44);
        chk("h_off", 64'(state), 64'(S_RUN));
        chk("h_off_done", 64'(done), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
